// File: rtl/time_report_tx.sv
// ---------------------------------------------------------------------------
// time_report_tx
//
// Serialises a time-of-day snapshot as ASCII "HH:MM:SS.CC" over a UART 8N1
// line. Build with TIME_REPORT_CRLF_EN defined to append CR LF to every
// frame (13 characters instead of 11).
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      UART bit rate; each bit lasts CLK_FREQ/BAUD clocks
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-high reset
//   i_start    one-cycle report request
//   i_hour     hours 0-23
//   i_min      minutes 0-59
//   i_sec      seconds 0-59
//   i_msec     centiseconds 0-99
//   uart_tx    registered serial line, idle high
//   o_busy     high while a frame is being sent
//   o_done     one-cycle pulse when the last stop bit completes
//   dbg_state  current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Request handshake: i_start is a valid-only strobe. It is accepted on any
// rising edge where i_start=1 and o_busy=0; the time inputs are captured on
// that same edge. A strobe seen while o_busy=1 is dropped, never queued.
// o_busy is already low in the cycle o_done pulses, so a request in that
// cycle is accepted and the next frame starts right after.
// ---------------------------------------------------------------------------
module time_report_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic [6:0] i_msec,
  output logic       uart_tx,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] dbg_state
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD;
  localparam int CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);

`ifdef TIME_REPORT_CRLF_EN
  localparam int NUM_CHARS = 13;
`else
  localparam int NUM_CHARS = 11;
`endif
  localparam logic [3:0] CHAR_LAST = 4'(NUM_CHARS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [3:0]       char_idx;
  logic [6:0]       tx_shift;   // remaining data bits of the current char
  logic [4:0]       hour_q;
  logic [5:0]       min_q;
  logic [5:0]       sec_q;
  logic [6:0]       msec_q;
  logic [7:0]       cur_char;
  logic             bit_done;

  assign dbg_state = state;
  assign bit_done  = (baud_cnt == CNT_LAST);

  function automatic logic [7:0] tens_ascii(input logic [6:0] v);
    logic [6:0] d;
    d = (v / 7'd10) % 7'd10;
    return 8'h30 + {1'b0, d};
  endfunction

  function automatic logic [7:0] units_ascii(input logic [6:0] v);
    logic [6:0] d;
    d = v % 7'd10;
    return 8'h30 + {1'b0, d};
  endfunction

  // Character selected by position within the frame, built from the
  // snapshot so input changes mid-frame have no effect.
  always_comb begin
    cur_char = 8'h00;
    case (char_idx)
      4'd0:    cur_char = tens_ascii({2'b00, hour_q});
      4'd1:    cur_char = units_ascii({2'b00, hour_q});
      4'd2:    cur_char = 8'h3A;
      4'd3:    cur_char = tens_ascii({1'b0, min_q});
      4'd4:    cur_char = units_ascii({1'b0, min_q});
      4'd5:    cur_char = 8'h3A;
      4'd6:    cur_char = tens_ascii({1'b0, sec_q});
      4'd7:    cur_char = units_ascii({1'b0, sec_q});
      4'd8:    cur_char = 8'h2E;
      4'd9:    cur_char = tens_ascii(msec_q);
      4'd10:   cur_char = units_ascii(msec_q);
`ifdef TIME_REPORT_CRLF_EN
      4'd11:   cur_char = 8'h0D;
      4'd12:   cur_char = 8'h0A;
`endif
      default: cur_char = 8'h00;
    endcase
  end

  // uart_tx always holds the level of the bit currently on the line; it is
  // updated on the same edge that moves to the next bit, so bit boundaries
  // land exactly every BIT_CLKS clocks with no idle gap between characters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      char_idx <= '0;
      tx_shift <= '0;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      msec_q   <= '0;
      uart_tx  <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            hour_q   <= i_hour;
            min_q    <= i_min;
            sec_q    <= i_sec;
            msec_q   <= i_msec;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            char_idx <= '0;
            uart_tx  <= 1'b0;
            o_busy   <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            uart_tx  <= cur_char[0];
            tx_shift <= cur_char[7:1];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              uart_tx  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[6:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (char_idx == CHAR_LAST) begin
              char_idx <= '0;
              uart_tx  <= 1'b1;
              o_busy   <= 1'b0;
              o_done   <= 1'b1;
              state    <= IDLE;
            end else begin
              char_idx <= char_idx + 4'd1;
              uart_tx  <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_report_tx.sv
// ---------------------------------------------------------------------------
// tb_time_report_tx
//
// Bench for time_report_tx with a shortened bit time (8 clocks per bit).
// The reference model builds the expected character list with decimal
// arithmetic and derives the expected line level for every clock of the
// frame from position alone: bit index = cycle / BIT, char = bit / 10.
// ---------------------------------------------------------------------------
module tb_time_report_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 125;
  localparam int B        = CLK_FREQ / BAUD;
`ifdef TIME_REPORT_CRLF_EN
  localparam int NCH = 13;
`else
  localparam int NCH = 11;
`endif
  localparam int FRAME_CLKS = NCH * 10 * B;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic [4:0] i_hour;
  logic [5:0] i_min;
  logic [5:0] i_sec;
  logic [6:0] i_msec;
  logic       uart_tx;
  logic       o_busy;
  logic       o_done;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  time_report_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_hour    (i_hour),
    .i_min     (i_min),
    .i_sec     (i_sec),
    .i_msec    (i_msec),
    .uart_tx   (uart_tx),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] frame_b [0:12];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] digit(input int v, input bit tens);
    int d;
    d = tens ? (v / 10) % 10 : v % 10;
    return 8'(48 + d);
  endfunction

  task automatic build_frame(input int h, input int m, input int s, input int c);
    frame_b[0]  = digit(h, 1);
    frame_b[1]  = digit(h, 0);
    frame_b[2]  = 8'h3A;
    frame_b[3]  = digit(m, 1);
    frame_b[4]  = digit(m, 0);
    frame_b[5]  = 8'h3A;
    frame_b[6]  = digit(s, 1);
    frame_b[7]  = digit(s, 0);
    frame_b[8]  = 8'h2E;
    frame_b[9]  = digit(c, 1);
    frame_b[10] = digit(c, 0);
    frame_b[11] = 8'h0D;
    frame_b[12] = 8'h0A;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_time(input int h, input int m, input int s, input int c);
    i_hour = 5'(h);
    i_min  = 6'(m);
    i_sec  = 6'(s);
    i_msec = 7'(c);
  endtask

  // Idle stretch: line must stay high, busy and done low.
  task automatic idle(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  // Called at a negedge. Requests a frame, checks every clock of it, decodes
  // each byte mid-bit against the scoreboard, and returns at the negedge of
  // the o_done cycle. ignore_char >= 0 fires an extra request inside that
  // character; scramble changes the inputs right after acceptance.
  task automatic run_frame(input int h, input int m, input int s, input int c,
                           input int ignore_char, input bit scramble, input string tag);
    int         wave_err;
    int         dones;
    int         bidx;
    int         ch;
    int         ign_c;
    logic       expb;
    logic [7:0] rx;
    build_frame(h, m, s, c);
    for (int i = 0; i < NCH; i++) exp_q.push_back(frame_b[i]);
    drive_time(h, m, s, c);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    if (scramble) drive_time(23, 59, 59, 99);
    wave_err = 0;
    dones    = 0;
    rx       = 8'h00;
    ign_c    = (ignore_char >= 0) ? ignore_char * 10 * B + B + 1 : -10;
    for (int cyc = 0; cyc < FRAME_CLKS; cyc++) begin
      @(negedge clk);
      ch   = cyc / (10 * B);
      bidx = (cyc / B) % 10;
      if (bidx == 0)      expb = 1'b0;
      else if (bidx == 9) expb = 1'b1;
      else                expb = frame_b[ch][bidx-1];
      if (uart_tx !== expb || o_busy !== 1'b1) wave_err++;
      if (o_done !== 1'b0) dones++;
      if (cyc % B == B / 2 && bidx >= 1 && bidx <= 8) begin
        rx[bidx-1] = uart_tx;
        if (bidx == 8) begin
          if (exp_q.size() == 0) chk({tag, "_extra_byte"}, 32'(rx), 32'hFFFF);
          else chk({tag, "_byte"}, 32'(rx), 32'(exp_q.pop_front()));
        end
      end
      if (cyc == ign_c) begin
        drive_time($urandom_range(0, 23), $urandom_range(0, 59),
                   $urandom_range(0, 59), $urandom_range(0, 99));
        i_start = 1'b1;
      end else if (cyc == ign_c + 1) begin
        i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    chk({tag, "_wave_err"}, 32'(wave_err), 32'd0);
    chk({tag, "_done_early"}, 32'(dones), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(o_done), 32'd1);
    chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
    chk({tag, "_tx_end"}, 32'(uart_tx), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    i_start = 1'b0;
    drive_time(0, 0, 0, 0);
    #1;
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(5, "idle_after_rst");

    // Directed frame 12:34:56.78.
    run_frame(12, 34, 56, 78, -1, 1'b0, "f_12345678");
    idle(4, "idle_a");

    // Inputs change right after acceptance; the snapshot must be sent.
    run_frame(3, 5, 9, 1, -1, 1'b1, "f_snap");

    // Request in the o_done cycle starts the next frame immediately.
    run_frame(0, 0, 0, 0, -1, 1'b0, "f_zero_chain");
    idle(3, "idle_b");

    // Extra request during character 4 is dropped and not queued.
    run_frame($urandom_range(0, 23), $urandom_range(0, 59),
              $urandom_range(0, 59), $urandom_range(0, 99), 4, 1'b0, "f_ignore");
    idle(3 * 10 * B, "idle_no_requeue");

    // Reset mid-DATA of character 6 aborts the frame at once.
    drive_time(7, 8, 9, 10);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (6 * 10 * B + 3 * B + 2) @(negedge clk);
    chk("pre_abort_busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_tx", 32'(uart_tx), 32'd1);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(3 * 10 * B, "idle_after_abort");

    // Randomised frames, some chained through the o_done cycle.
    for (int k = 0; k < 5; k++) begin
      run_frame($urandom_range(0, 23), $urandom_range(0, 59),
                $urandom_range(0, 59), $urandom_range(0, 99), -1, 1'b0, "f_rand");
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 20), "idle_rand");
    end
    idle(2 * B, "idle_final");
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
